adder_sub_pipe: RTL and testbench

// - Parametrised, pipelined signed adder/subtractor; successor to the 16-bit combinational adder_sub.
// - Adds wrap/saturate modes, valid/ready flow control with per-stage bubble collapse, and a

---
 rtl/adder_sub_pkg.sv | 48 ++++
 rtl/adder_sub_core.sv | 53 +++++
 rtl/adder_sub_pipe.sv | 131 +++++++++++++
 tb/tb_adder_sub_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sub_pkg
//  Purpose  : Shared types and helpers for the pipelined signed adder/subtractor.
//             mode_t  - operation select (wrap/saturate x add/sub)
//             res_t   - one result word as carried through the pipeline
//             sat_limits() - signed MAX/MIN for a given operand width
//  Revision : 1.0  initial release
// ============================================================================
package adder_sub_pkg;

    // Widest operand the shared result struct can carry; narrower instances
    // use the low WIDTH bits of the Out field.
    localparam int c_RES_MAX_W = 64;

    typedef enum logic [1:0] {
        ADD_W = 2'b00,
        SUB_W = 2'b01,
        ADD_S = 2'b10,
        SUB_S = 2'b11
    } mode_t;

    typedef struct packed {
        logic [c_RES_MAX_W-1:0] Out;
        logic                   over;
        logic                   carry;
    } res_t;

    typedef struct packed {
        logic [c_RES_MAX_W-1:0] max_v;
        logic [c_RES_MAX_W-1:0] min_v;
    } sat_lim_t;

    // Signed limits for a two's-complement word of the given width:
    // min = 1 << (width-1), max = min - 1 (both confined to the low width bits).
    function automatic sat_lim_t sat_limits(input int width);
        sat_lim_t lim;
        lim.min_v             = '0;
        lim.min_v[width-1]    = 1'b1;
        lim.max_v             = '0;
        for (int i = 0; i < width - 1; i++) begin
            lim.max_v[i] = 1'b1;
        end
        return lim;
    endfunction

endpackage : adder_sub_pkg
`default_nettype wire

// File: rtl/adder_sub_core.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sub_core
//  Purpose  : Combinational WIDTH-bit signed add/subtract with optional
//             saturation, producing Out / over / carry in a res_t word.
//  Ports    : op1, op2 [WIDTH] - signed operands
//             mode     [2]     - ADD_W, SUB_W, ADD_S, SUB_S
//             res      res_t   - Out (low WIDTH bits), over, carry
//  Revision : 1.0  initial release
// ============================================================================
module adder_sub_core
    import adder_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  mode_t            mode,
    output res_t             res
);

    localparam sat_lim_t c_LIM = sat_limits(WIDTH);

    logic             w_sub;
    logic             w_sat;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_over;

    always_comb begin
        w_sub   = (mode == SUB_W) || (mode == SUB_S);
        w_sat   = (mode == ADD_S) || (mode == SUB_S);
        // Subtraction as op1 + ~op2 + 1, so bit WIDTH is the no-borrow flag.
        w_b_eff = w_sub ? ~op2 : op2;
        w_sum   = {1'b0, op1} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        // Overflow: like-signed addends whose sum flips sign.
        w_over  = (op1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != op1[WIDTH-1]);

        res       = '0;
        res.over  = w_over;
        res.carry = w_sum[WIDTH];
        if (w_sat && w_over) begin
            // The exact result always lies on the side of op1's sign.
            res.Out[WIDTH-1:0] = op1[WIDTH-1] ? c_LIM.min_v[WIDTH-1:0]
                                              : c_LIM.max_v[WIDTH-1:0];
        end else begin
            res.Out[WIDTH-1:0] = w_sum[WIDTH-1:0];
        end
    end

endmodule : adder_sub_core
`default_nettype wire

// File: rtl/adder_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sub_pipe
//  Purpose  : LAT-stage pipelined signed adder/subtractor with valid/ready
//             flow control, per-stage bubble collapse and a saturating
//             overflow event counter.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid / in_ready   - input handshake (op1, op2, mode)
//             out_valid / out_ready - output handshake (Out, over, carry)
//             ovf_cnt [CNT_W]       - delivered results with over=1 (sticky max)
//             cnt_clr               - synchronous clear of ovf_cnt
//  Revision : 1.0  initial release
// ============================================================================
module adder_sub_pipe
    import adder_sub_pkg::*;
#(
    parameter int WIDTH = 16,   // 2..64
    parameter int LAT   = 2,    // 1..4
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             over,
    output logic             carry,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             cnt_clr
);

    res_t             w_core_res;
    res_t             w_up_res [1:LAT];   // value offered to each stage
    logic [LAT:1]     w_up_vld;
    logic [LAT:1]     w_rdy;              // stage i may load this cycle
    logic             w_full_tail;
    logic             w_accept;
    logic             w_ovf_evt;

    res_t             r_res    [1:LAT];
    logic [LAT:1]     r_vld;
    logic             r_init;             // holds off in_ready until the first clock after reset
    logic [CNT_W-1:0] r_ovf_cnt;

    adder_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op1  (op1),
        .op2  (op2),
        .mode (mode_t'(mode)),
        .res  (w_core_res)
    );

    // Stage i can load unless it and every stage after it are full while the
    // consumer is stalling. Equivalent to rdy[i] = !v[i] || rdy[i+1] unrolled,
    // written without a self-referencing vector.
    always_comb begin
        w_rdy       = '0;
        w_full_tail = 1'b1;
        for (int i = LAT; i >= 1; i--) begin
            w_full_tail = w_full_tail && r_vld[i];
            w_rdy[i]    = !w_full_tail || out_ready;
        end
    end

    assign in_ready = r_init && w_rdy[1];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_up_vld = '0;
        for (int i = 1; i <= LAT; i++) begin
            w_up_res[i] = '0;
        end
        w_up_vld[1] = w_accept;
        w_up_res[1] = w_core_res;
        for (int i = 2; i <= LAT; i++) begin
            w_up_vld[i] = r_vld[i-1];
            w_up_res[i] = r_res[i-1];
        end
    end

    assign w_ovf_evt = r_vld[LAT] && out_ready && r_res[LAT].over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init    <= 1'b0;
            r_vld     <= '0;
            r_ovf_cnt <= '0;
            for (int i = 1; i <= LAT; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_init <= 1'b1;
            for (int i = 1; i <= LAT; i++) begin
                if (w_rdy[i]) begin
                    r_vld[i] <= w_up_vld[i];
                    // Data only moves with a valid word, so a drained output
                    // keeps showing the last delivered result.
                    if (w_up_vld[i]) begin
                        r_res[i] <= w_up_res[i];
                    end
                end
            end

            if (cnt_clr) begin
                r_ovf_cnt <= w_ovf_evt ? CNT_W'(1) : '0;
            end else if (w_ovf_evt && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_vld[LAT];
    assign Out       = r_res[LAT].Out[WIDTH-1:0];
    assign over      = r_res[LAT].over;
    assign carry     = r_res[LAT].carry;
    assign ovf_cnt   = r_ovf_cnt;

    // Upper bits of the shared result struct are constant zero here.
    if (WIDTH < c_RES_MAX_W) begin : g_pad_unused
        logic w_unused_pad;
        assign w_unused_pad = ^r_res[LAT].Out[c_RES_MAX_W-1:WIDTH];
    end

endmodule : adder_sub_pipe
`default_nettype wire

// File: tb/tb_adder_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_sub_pipe
//  Purpose  : Self-checking bench for adder_sub_pipe (WIDTH=16, LAT=2, CNT_W=8)
//             plus a CNT_W=2 instance for counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_sub_pipe;
    import adder_sub_pkg::*;

    typedef struct packed {
        logic [15:0] out;
        logic        over;
        logic        carry;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr   = 1'b0;
    logic [15:0] op1       = '0;
    logic [15:0] op2       = '0;
    logic [1:0]  mode      = '0;
    logic        in_ready;
    logic        out_valid;
    logic        over;
    logic        carry;
    logic [15:0] Out;
    logic [7:0]  ovf_cnt;

    logic        c2_in_valid  = 1'b0;
    logic        c2_out_ready = 1'b1;
    logic        c2_cnt_clr   = 1'b0;
    logic [15:0] c2_op1       = '0;
    logic [15:0] c2_op2       = '0;
    logic [1:0]  c2_mode      = '0;
    logic        c2_in_ready;
    logic        c2_out_valid;
    logic        c2_over;
    logic        c2_carry;
    logic [15:0] c2_out;
    logic [1:0]  c2_ovf_cnt;

    adder_sub_pipe #(.WIDTH(16), .LAT(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .Out(Out), .over(over), .carry(carry),
        .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
    );

    adder_sub_pipe #(.WIDTH(16), .LAT(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
        .op1(c2_op1), .op2(c2_op2), .mode(c2_mode), .out_valid(c2_out_valid),
        .out_ready(c2_out_ready), .Out(c2_out), .over(c2_over), .carry(c2_carry),
        .ovf_cnt(c2_ovf_cnt), .cnt_clr(c2_cnt_clr)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   n_acc = 0;
    exp_t q[$];
    exp_t m_e;

    logic [15:0] tbl [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF,
                             16'h8000, 16'd1000, 16'hFC18, 16'h4000};

    // Reference: exact integer arithmetic, then range/saturation decisions.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] m);
        exp_t e;
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   ua = int'(a);
        int   ub = int'(b);
        int   ex;
        ex      = m[0] ? (sa - sb) : (sa + sb);
        e.over  = (ex > 32767) || (ex < -32768);
        e.carry = m[0] ? (ua >= ub) : ((ua + ub) > 65535);
        if (m[1] && e.over) e.out = (ex > 0) ? 16'h7FFF : 16'h8000;
        else                e.out = ex[15:0];
        return e;
    endfunction

    // Scoreboard consumer: every handshake on the output pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL deliver_unexpected: got Out=%0d with no result outstanding", $signed(Out));
            end else begin
                m_e = q.pop_front();
                if ({Out, over, carry} !== {m_e.out, m_e.over, m_e.carry})
                    $display("FAIL result: got Out=%0d over=%0b carry=%0b, expected Out=%0d over=%0b carry=%0b",
                             $signed(Out), over, carry, $signed(m_e.out), m_e.over, m_e.carry);
                else
                    n_pass++;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input exp_t e);
        bit ok;
        int t;
        op1 = a; op2 = b; mode = m; in_valid = 1'b1;
        ok = 1'b0; t = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=0 for 200 cycles, expected 1");
        end else begin
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (q.size() == 0) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, Out, over, carry, ovf_cnt, in_ready, c2_ovf_cnt} !== '0)
            $display("FAIL reset_state: got out_valid=%0b Out=%0h over=%0b carry=%0b ovf_cnt=%0d in_ready=%0b c2_cnt=%0d, expected all 0",
                     out_valid, Out, over, carry, ovf_cnt, in_ready, c2_ovf_cnt);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ready_before_first_clk: got %0b, expected 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b, expected 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        out_ready = 1'b1;
        send(16'd2000, 16'd1000, ADD_W, {16'd3000, 1'b0, 1'b0});
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%0b one cycle after accept, expected 0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL latency_lat2: out_valid=%0b two cycles after accept, expected 1", out_valid);
        else n_pass++;
        @(posedge clk); #1;
        send(16'd2000, 16'd1000,  SUB_W, {16'd1000, 1'b0, 1'b1});
        send(16'd2000, 16'hFC18,  SUB_W, {16'd3000, 1'b0, 1'b0});
        send(16'hF830, 16'hFC18,  ADD_W, {16'hF448, 1'b0, 1'b1});
        drain(ok);
        n_total++;
        if (!ok || ovf_cnt !== 8'd0) $display("FAIL basic_drain: drained=%0b ovf_cnt=%0d, expected drained=1 ovf_cnt=0", ok, ovf_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        send(16'h7FFF, 16'h0001, ADD_W, {16'h8000, 1'b1, 1'b0});
        send(16'h7FFF, 16'h0001, ADD_S, {16'h7FFF, 1'b1, 1'b0});
        send(16'h8000, 16'h0001, SUB_S, {16'h8000, 1'b1, 1'b1});
        drain(ok);
        n_total++;
        if (!ok || ovf_cnt !== 8'd3) $display("FAIL ovf_count: drained=%0b ovf_cnt=%0d, expected drained=1 ovf_cnt=3", ok, ovf_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          ok;
        time         t0;
        int          n_ovf;
        logic [15:0] a, b;
        logic [1:0]  m;
        exp_t        e;
        out_ready = 1'b1;
        n_ovf = 0;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            a = tbl[$urandom_range(7, 0)];
            b = tbl[$urandom_range(7, 0)];
            m = 2'(i % 4);
            e = model(a, b, m);
            if (e.over) n_ovf++;
            send(a, b, m, e);
        end
        n_total++;
        if (($time - t0) != 80) $display("FAIL throughput: 8 inputs took %0t time units, expected 80", $time - t0);
        else n_pass++;
        drain(ok);
        n_total++;
        if (!ok || ovf_cnt !== 8'(3 + n_ovf)) $display("FAIL b2b_count: drained=%0b ovf_cnt=%0d, expected drained=1 ovf_cnt=%0d", ok, ovf_cnt, 3 + n_ovf);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit          ok;
        bit          seen;
        logic [17:0] held;
        logic [15:0] ba [6];
        logic [15:0] bb [6];
        logic [1:0]  bm [6];
        for (int i = 0; i < 6; i++) begin
            ba[i] = 16'(100 * (i + 1));
            bb[i] = 16'(i + 3);
            bm[i] = (i % 2 == 0) ? ADD_W : SUB_W;
        end
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(ba[i], bb[i], bm[i], model(ba[i], bb[i], bm[i]));
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    if (!in_ready) seen = 1'b1;
                end
                n_total++;
                if (!seen || n_acc != 2) $display("FAIL bp_ready_drop: seen=%0b accepted=%0d, expected seen=1 accepted=2", seen, n_acc);
                else n_pass++;
                held = {Out, over, carry};
                n_total++;
                if (out_valid !== 1'b1) $display("FAIL bp_valid: got out_valid=%0b while stalled, expected 1", out_valid);
                else n_pass++;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    n_total++;
                    if ({Out, over, carry} !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                        $display("FAIL bp_hold: got word=%0h valid=%0b in_ready=%0b, expected word=%0h valid=1 in_ready=0",
                                 {Out, over, carry}, out_valid, in_ready, held);
                    else n_pass++;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(ok);
        n_total++;
        if (!ok || n_acc != 6) $display("FAIL bp_delivered: drained=%0b accepted=%0d, expected drained=1 accepted=6", ok, n_acc);
        else n_pass++;
    endtask

    task automatic test_counter();
        int acc;
        bit seen;
        c2_op1 = 16'h7FFF; c2_op2 = 16'h0001; c2_mode = ADD_W; c2_out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            c2_in_valid = 1'b1;
            @(negedge clk);
            if (c2_in_ready) acc++;
            @(posedge clk); #1;
        end
        c2_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (acc != 5 || c2_ovf_cnt !== 2'd3) $display("FAIL cnt_saturate: accepted=%0d ovf_cnt=%0d, expected accepted=5 ovf_cnt=3", acc, c2_ovf_cnt);
        else n_pass++;
        c2_in_valid = 1'b1;
        @(posedge clk); #1;
        c2_in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (c2_out_valid) seen = 1'b1;
        end
        c2_cnt_clr = 1'b1;
        @(posedge clk); #1;
        c2_cnt_clr = 1'b0;
        n_total++;
        if (!seen || c2_ovf_cnt !== 2'd1) $display("FAIL cnt_clr_with_event: seen=%0b ovf_cnt=%0d, expected seen=1 ovf_cnt=1", seen, c2_ovf_cnt);
        else n_pass++;
        c2_cnt_clr = 1'b1;
        @(posedge clk); #1;
        c2_cnt_clr = 1'b0;
        n_total++;
        if (c2_ovf_cnt !== 2'd0) $display("FAIL cnt_clr_alone: got ovf_cnt=%0d, expected 0", c2_ovf_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit stale;
        out_ready = 1'b0;
        send(16'd11, 16'd22, ADD_W, {16'd33, 1'b0, 1'b0});
        send(16'd50, 16'd8,  SUB_W, {16'd42, 1'b0, 1'b1});
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || ovf_cnt === 8'd0) $display("FAIL midop_pre: out_valid=%0b ovf_cnt=%0d, expected out_valid=1 ovf_cnt>0", out_valid, ovf_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        n_total++;
        if (out_valid !== 1'b0 || ovf_cnt !== 8'd0 || Out !== 16'd0)
            $display("FAIL midop_reset: out_valid=%0b ovf_cnt=%0d Out=%0d, expected 0 0 0", out_valid, ovf_cnt, Out);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_total++;
        if (stale) $display("FAIL midop_stale: got out_valid=1 after reset release, expected 0");
        else n_pass++;
        @(posedge clk); #1;
        send(16'd5, 16'd7, ADD_W, {16'd12, 1'b0, 1'b0});
        drain(ok);
        n_total++;
        if (!ok) $display("FAIL midop_after: drained=%0b, expected 1", ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_counter();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_adder_sub_pipe
`default_nettype wire
